// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with a word FIFO in front of it. Producers write words
//   through a valid/ready port. The serialiser pops words and sends them as
//   start / data (LSB first) / optional parity / stop frames. Back-to-back
//   frames have no idle bit between them.
//
// Handshake: a word is written on every rising edge where TX_VALID and
//   TX_READY are both high. TX_READY depends only on the stored count, never
//   on TX_VALID. Holding TX_VALID while TX_READY is low stalls the producer;
//   the word stays on TX_DATA until it is accepted.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_N        synchronous active-low reset
//   TX_DATA      word to transmit (DATA_BITS wide)
//   TX_VALID     producer has a word on TX_DATA
//   TX_READY     FIFO has a free slot
//   TX_EN        1 = frames may start; 0 = hold after the current frame
//   FIFO_COUNT   words stored, not counting the frame being sent
//   BUSY         a frame is in flight (FSM not in IDLE)
//   FLAG_TXE     FIFO empty and not BUSY
//   UART_TX_PIN  registered serial line, idle high
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100000000,
   parameter int UART_BPS   = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic [DATA_BITS-1:0]        TX_DATA,
   input  logic                        TX_VALID,
   output logic                        TX_READY,
   input  logic                        TX_EN,
   output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
   output logic                        BUSY,
   output logic                        FLAG_TXE,
   output logic                        UART_TX_PIN
);
   localparam int          BPS_CNT   = CLK_FREQ / UART_BPS;
   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BAUD_LAST = 16'(BPS_CNT - 1);
   localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
   localparam logic        ODD_PAR   = (PARITY == 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state_q, state_d;
   logic [15:0]          baud_q, baud_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 pin_q, pin_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW:0]          count_q, count_d;
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

   logic                 push;
   logic                 pop;
   logic                 fifo_empty;
   logic                 bit_end;
   logic [DATA_BITS-1:0] head;

   assign fifo_empty  = (count_q == '0);
   assign TX_READY    = (count_q != FULL_CNT);
   assign push        = TX_VALID & TX_READY;
   assign head        = mem_q[rd_ptr_q];
   assign bit_end     = (baud_q == BAUD_LAST);

   assign FIFO_COUNT  = count_q;
   assign BUSY        = (state_q != IDLE);
   assign FLAG_TXE    = fifo_empty & (state_q == IDLE);
   assign UART_TX_PIN = pin_q;

   // Serialiser next state. bit_q counts data bits in DATA and stop bits in
   // STOP; baud_q counts cycles within the current bit and is held at zero in
   // IDLE.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pin_d   = pin_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            pin_d  = 1'b1;
            pop    = !fifo_empty && TX_EN;
         end
         START: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               pin_d   = shift_q[0];
               shift_d = shift_q >> 1;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == DATA_LAST) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     pin_d   = par_q;
                     state_d = PAR;
                  end else begin
                     pin_d   = 1'b1;
                     state_d = STOP;
                  end
               end else begin
                  bit_d   = bit_q + 4'd1;
                  pin_d   = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         PAR: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               pin_d   = 1'b1;
               state_d = STOP;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  // TX_EN is only looked at here and in IDLE, so a frame
                  // already started always runs to completion.
                  if (!fifo_empty && TX_EN) begin
                     pop = 1'b1;
                  end else begin
                     pin_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            pin_d   = 1'b1;
         end
      endcase
      // Popping loads the next word and starts its start bit this edge.
      // Parity is computed here once so the PAR state only replays it.
      if (pop) begin
         state_d = START;
         baud_d  = '0;
         bit_d   = '0;
         pin_d   = 1'b0;
         shift_d = head;
         par_d   = (^head) ^ ODD_PAR;
      end
   end

   // FIFO pointers wrap naturally because FIFO_DEPTH is a power of two.
   // A pop only happens with count > 0 and a push only with count < depth,
   // so a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         pin_q    <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         pin_q    <= pin_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; only slots behind a valid pointer are read.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= TX_DATA;
      end
   end

endmodule
